// File: rtl/avalon_bcd_writer_de1soc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_de1soc_pkg
// Purpose  : Shared types and constants for the DE1-SoC BCD segment writer.
// Revision : 1.0
// ============================================================================
package seg_de1soc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        WRITE   = 2'd2
    } state_t;

    localparam int         DIGIT_W          = 4;
    localparam logic [3:0] WRITE_BYTEENABLE = 4'b0001;

    // Largest value representable with n decimal digits (10^n - 1).
    function automatic logic [63:0] max_decimal(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r - 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/avalon_bcd_writer_de1soc_if.sv
`default_nettype none
// ============================================================================
// Module   : avalon_bcd_writer_de1soc_if
// Purpose  : Avalon-MM write channel towards the seven-segment register block.
// Revision : 1.0
// ============================================================================
interface avalon_bcd_writer_de1soc_if;

    logic [2:0]  avm_address_o;
    logic [3:0]  avm_byteenable_o;
    logic        avm_write_o;
    logic [31:0] avm_writedata_o;
    logic        avm_waitrequest_i;

    modport master (
        output avm_address_o,
        output avm_byteenable_o,
        output avm_write_o,
        output avm_writedata_o,
        input  avm_waitrequest_i
    );

    modport slave (
        input  avm_address_o,
        input  avm_byteenable_o,
        input  avm_write_o,
        input  avm_writedata_o,
        output avm_waitrequest_i
    );

endinterface
`default_nettype wire

// File: rtl/avalon_bcd_writer_de1soc_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq
// Purpose  : Iterative double-dabble, one shift-and-adjust step per cycle.
// Revision : 1.0
// ============================================================================
module bin_to_bcd_seq
    import seg_de1soc_pkg::*;
#(
    parameter int NUM_SEGMENT = 6,
    parameter int BIN_WIDTH   = 20
) (
    input  wire logic                           clk,
    input  wire logic                           rst_n,
    input  wire logic                           start_i,
    input  wire logic [BIN_WIDTH-1:0]           bin_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic [DIGIT_W*NUM_SEGMENT-1:0]      bcd_o
);

    localparam int c_cnt_w = $clog2(BIN_WIDTH + 1);
    localparam int c_bcd_w = DIGIT_W * NUM_SEGMENT;

    logic [BIN_WIDTH-1:0] r_bin;
    logic [c_bcd_w-1:0]   r_bcd;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_bcd_w-1:0]   w_adj;
    logic [c_bcd_w-1:0]   w_bcd_step;

    for (genvar k = 0; k < NUM_SEGMENT; k++) begin : g_nibble
        assign w_adj[k*DIGIT_W +: DIGIT_W] =
            (r_bcd[k*DIGIT_W +: DIGIT_W] >= 4'd5) ? r_bcd[k*DIGIT_W +: DIGIT_W] + 4'd3
                                                  : r_bcd[k*DIGIT_W +: DIGIT_W];
    end

    assign w_bcd_step = {w_adj[c_bcd_w-2:0], r_bin[BIN_WIDTH-1]};
    assign busy_o     = (r_cnt != '0);
    assign done_o     = (r_cnt == c_cnt_w'(1));
    // Look ahead during the final step so the caller can register digit 0 on the same edge.
    assign bcd_o      = done_o ? w_bcd_step : r_bcd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
        end else if (start_i) begin
            r_bin <= bin_i;
            r_bcd <= '0;
            r_cnt <= c_cnt_w'(BIN_WIDTH);
        end else if (busy_o) begin
            r_bin <= r_bin << 1;
            r_bcd <= w_bcd_step;
            r_cnt <= r_cnt - c_cnt_w'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/avalon_bcd_writer_de1soc.sv
`default_nettype none
// ============================================================================
// Module   : avalon_bcd_writer_de1soc
// Purpose  : Accepts a binary value, converts to decimal, writes one digit per
//            seven-segment register over Avalon-MM.
// Revision : 1.0
// ============================================================================
module avalon_bcd_writer_de1soc
    import seg_de1soc_pkg::*;
#(
    parameter int NUM_SEGMENT = 6,
    parameter int BIN_WIDTH   = 20
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic [BIN_WIDTH-1:0] value_i,
    input  wire logic                 valid_i,
    output logic                      ready_o,
    output logic                      overflow_o,
    avalon_bcd_writer_de1soc_if.master avm
);

    localparam logic [63:0] c_max_value = max_decimal(NUM_SEGMENT);
    localparam int          c_bcd_w     = DIGIT_W * NUM_SEGMENT;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_overflow;
    logic                    r_write;
    logic [2:0]              r_addr;
    logic [3:0]              r_be;
    logic [31:0]             r_wdata;

    logic                    w_take;
    logic                    w_first;
    logic                    w_advance;
    logic                    w_finish;
    logic                    w_write_done;
    logic                    w_last_addr;
    logic [2:0]              w_addr_next;
    logic                    w_busy;
    logic                    w_done;
    logic [c_bcd_w-1:0]      w_bcd;
    logic [DIGIT_W-1:0]      w_digits [8];

    bin_to_bcd_seq #(
        .NUM_SEGMENT (NUM_SEGMENT),
        .BIN_WIDTH   (BIN_WIDTH)
    ) u_bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (w_take),
        .bin_i   (value_i),
        .busy_o  (w_busy),
        .done_o  (w_done),
        .bcd_o   (w_bcd)
    );

    // Saturated values display as all nines regardless of the converter result.
    for (genvar k = 0; k < 8; k++) begin : g_digit
        if (k < NUM_SEGMENT) begin : g_used
            assign w_digits[k] = r_overflow ? 4'd9 : w_bcd[k*DIGIT_W +: DIGIT_W];
        end else begin : g_unused
            assign w_digits[k] = '0;
        end
    end

    assign w_addr_next  = r_addr + 3'd1;
    assign w_write_done = r_write && !avm.avm_waitrequest_i;
    assign w_last_addr  = (r_addr == 3'(NUM_SEGMENT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (valid_i)                     w_state_next = CONVERT;
            CONVERT: if (w_done)                      w_state_next = WRITE;
            WRITE:   if (w_write_done && w_last_addr) w_state_next = IDLE;
            default:                                  w_state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_o   = (r_state == IDLE);
        w_take    = 1'b0;
        w_first   = 1'b0;
        w_advance = 1'b0;
        w_finish  = 1'b0;
        case (r_state)
            IDLE:    w_take    = valid_i;
            CONVERT: w_first   = w_done;
            WRITE: begin
                w_advance = w_write_done && !w_last_addr;
                w_finish  = w_write_done &&  w_last_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
        end else begin
            if (w_take) begin
                r_overflow <= (64'(value_i) > c_max_value);
            end
            if (w_first) begin
                r_write <= 1'b1;
                r_addr  <= '0;
                r_be    <= WRITE_BYTEENABLE;
                r_wdata <= {{(32-DIGIT_W){1'b0}}, w_digits[0]};
            end else if (w_advance) begin
                r_addr  <= w_addr_next;
                r_wdata <= {{(32-DIGIT_W){1'b0}}, w_digits[w_addr_next]};
            end else if (w_finish) begin
                r_write <= 1'b0;
                r_be    <= '0;
            end
        end
    end

    assign overflow_o           = r_overflow;
    assign avm.avm_write_o      = r_write;
    assign avm.avm_address_o    = r_addr;
    assign avm.avm_byteenable_o = r_be;
    assign avm.avm_writedata_o  = r_wdata;

endmodule
`default_nettype wire
